// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
//   Shared constants and types for the stopwatch datapath.
//
//   Contents:
//     TIMER_CLK_HZ        system clock frequency
//     DEBOUNCE_10MS       stable cycles required before a key level is accepted
//     CLR_HOLD_DEFAULT    cycles the clear request is held (longer than one tick)
//     TICK_PERIOD_CYCLES  worst-case spacing of 10 ms tick edges, in clk cycles
//     db_state_t          debouncer state encoding
// -----------------------------------------------------------------------------
package timer_pkg;

    localparam int TIMER_CLK_HZ       = 100_000_000;
    localparam int DEBOUNCE_10MS      = 1_000_000;
    localparam int CLR_HOLD_DEFAULT   = 1_100_000;
    localparam int TICK_PERIOD_CYCLES = 1_000_002;

    // Debouncer states. CHK_* are the "candidate level seen, counting" states.
    typedef enum logic [1:0] {
        DB_LOW      = 2'd0,
        DB_CHK_HIGH = 2'd1,
        DB_HIGH     = 2'd2,
        DB_CHK_LOW  = 2'd3
    } db_state_t;

endpackage : timer_pkg

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Synchronises one raw, bouncing push-button into the clk domain, accepts a
//   new level only after it has been stable for DEBOUNCE_CYCLES consecutive
//   cycles, and emits a single-cycle pulse when the debounced level goes high.
//
//   Parameters:
//     DEBOUNCE_CYCLES  stable cycles required (>= 2)
//
//   Ports:
//     clk    in   system clock
//     rst    in   synchronous, active-high reset
//     key    in   raw asynchronous button, active-high
//     press  out  registered one-cycle pulse on the cycle the FSM enters HIGH
// -----------------------------------------------------------------------------
module key_debounce
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    // The counter holds "cycles already seen stable"; the transition fires on
    // the edge that would make it reach DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_meta;
    logic             sync;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             press_nxt;

    // Saturating increment: the counter never wraps back to zero.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // NOTE: every register here uses <= so all flops sample the pre-edge values
    // of each other; with = the two synchroniser stages would collapse into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
            state     <= DB_LOW;
            cnt       <= '0;
            press     <= 1'b0;
        end else begin
            sync_meta <= key;
            sync      <= sync_meta;
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            press     <= press_nxt;
        end
    end

    // NOTE: defaults are assigned before the case so every path drives every
    // output; a missing assignment on some path would infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;

        case (state)
            DB_LOW: begin
                if (sync) begin
                    state_nxt = DB_CHK_HIGH;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end

            DB_CHK_HIGH: begin
                if (!sync) begin
                    state_nxt = DB_LOW;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = DB_HIGH;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end

            DB_HIGH: begin
                if (!sync) begin
                    state_nxt = DB_CHK_LOW;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt   = '0;
                end
            end

            DB_CHK_LOW: begin
                if (sync) begin
                    state_nxt = DB_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_nxt = DB_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end

            default: begin
                state_nxt = DB_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule : key_debounce

// File: rtl/timer_key_conditioner.sv
// -----------------------------------------------------------------------------
// timer_key_conditioner
//   Conditions the start/stop and clear buttons for the stopwatch counting
//   stage. Each button is debounced; an accepted start/stop press toggles
//   pause, an accepted clear press forces pause high and raises clr for
//   CLR_HOLD_CYCLES cycles so the slow 10 ms stage is sure to sample it.
//
//   Parameters:
//     DEBOUNCE_CYCLES  stable cycles before a key level is accepted (>= 2)
//     CLR_HOLD_CYCLES  cycles clr stays high per accepted clear press
//                      (must exceed one 10 ms tick period)
//
//   Ports:
//     clk       in   100 MHz system clock
//     rst       in   synchronous, active-high reset
//     key_ss    in   raw start/stop button
//     key_clr   in   raw clear button
//     pause     out  1 = counting stopped (registered, resets to 1)
//     clr       out  clear request to the counting stage (registered)
//     ss_press  out  one-cycle pulse per accepted start/stop press
// -----------------------------------------------------------------------------
module timer_key_conditioner
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int CLR_HOLD_CYCLES = CLR_HOLD_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic key_ss,
    input  logic key_clr,
    output logic pause,
    output logic clr,
    output logic ss_press
);

    localparam int              HOLD_W    = $clog2(CLR_HOLD_CYCLES);
    // clr is already high on the load edge, so the counter covers the
    // remaining CLR_HOLD_CYCLES-1 cycles and clr drops on the edge after it
    // reaches zero.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLR_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic              clr_press;
    logic              pause_nxt;
    logic              clr_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_nxt;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_ss (
        .clk   (clk),
        .rst   (rst),
        .key   (key_ss),
        .press (ss_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_clr (
        .clk   (clk),
        .rst   (rst),
        .key   (key_clr),
        .press (clr_press)
    );

    // Priority: a clear press beats everything (including a simultaneous
    // start/stop press), an active hold pins pause high and swallows start/stop
    // presses, and only when idle does a start/stop press toggle pause.
    always_comb begin
        pause_nxt    = pause;
        clr_nxt      = clr;
        hold_cnt_nxt = hold_cnt;

        if (clr_press) begin
            pause_nxt    = 1'b1;
            clr_nxt      = 1'b1;
            hold_cnt_nxt = HOLD_LAST;
        end else if (clr) begin
            pause_nxt = 1'b1;
            if (hold_cnt == '0) begin
                clr_nxt = 1'b0;
            end else begin
                hold_cnt_nxt = hold_cnt - HOLD_ONE;
            end
        end else if (ss_press) begin
            pause_nxt = ~pause;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pause    <= 1'b1;
            clr      <= 1'b0;
            hold_cnt <= '0;
        end else begin
            pause    <= pause_nxt;
            clr      <= clr_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

endmodule : timer_key_conditioner

// File: tb/tb_timer_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_timer_key_conditioner
//   Directed bench with DEBOUNCE_CYCLES=4. The main instance uses
//   CLR_HOLD_CYCLES=6; a second instance with CLR_HOLD_CYCLES=16 shares all
//   stimulus so a second clear press can land inside a running hold.
//   "Cycle n" of a scenario is the value observed 1 time unit after the n-th
//   rising edge following the step that changed the key.
// -----------------------------------------------------------------------------
module tb_timer_key_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic key_ss;
    logic key_clr;
    logic pause;
    logic clr;
    logic ss_press;
    logic pause_l;
    logic clr_l;
    logic ss_press_l;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    timer_key_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .CLR_HOLD_CYCLES (6)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_ss   (key_ss),
        .key_clr  (key_clr),
        .pause    (pause),
        .clr      (clr),
        .ss_press (ss_press)
    );

    timer_key_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .CLR_HOLD_CYCLES (16)
    ) dut_long (
        .clk      (clk),
        .rst      (rst),
        .key_ss   (key_ss),
        .key_clr  (key_clr),
        .pause    (pause_l),
        .clr      (clr_l),
        .ss_press (ss_press_l)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic observed, input logic expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        rst     = 1'b1;
        key_ss  = 1'b0;
        key_clr = 1'b0;

        // Reset for two cycles.
        step();
        step();
        check("rst_pause", pause, 1'b1);
        check("rst_clr", clr, 1'b0);
        check("rst_ss_press", ss_press, 1'b0);
        rst = 1'b0;
        idle(3);
        check("post_rst_pause", pause, 1'b1);

        // Clean start/stop press held 20 cycles: pulse at 6, pause 1->0 at 7.
        key_ss = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            check($sformatf("ss1_press[%0d]", n), ss_press, (n == 6));
            check($sformatf("ss1_pause[%0d]", n), pause, (n < 7));
        end
        key_ss = 1'b0;
        // Release: no pulse, pause unchanged.
        for (int n = 1; n <= 12; n++) begin
            step();
            check($sformatf("ss1_rel_press[%0d]", n), ss_press, 1'b0);
            check($sformatf("ss1_rel_pause[%0d]", n), pause, 1'b0);
        end

        // Second clean press returns pause to 1.
        key_ss = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            check($sformatf("ss2_press[%0d]", n), ss_press, (n == 6));
            check($sformatf("ss2_pause[%0d]", n), pause, (n >= 7));
        end
        key_ss = 1'b0;
        idle(20);

        // Bounce 1,0,1,0 then held 0: nothing happens.
        key_ss = 1'b1;
        step();
        key_ss = 1'b0;
        step();
        key_ss = 1'b1;
        step();
        key_ss = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            step();
            check($sformatf("bounce_press[%0d]", n), ss_press, 1'b0);
            check($sformatf("bounce_pause[%0d]", n), pause, 1'b1);
        end
        idle(5);

        // Clear scenario: first get pause to 0.
        key_ss = 1'b1;
        idle(8);
        check("clr_setup_pause", pause, 1'b0);
        key_ss = 1'b0;
        idle(20);

        // key_clr held 10 cycles; key_ss pressed at cycle 2 so its accepted
        // press (cycle 8) lands inside the hold and must be ignored.
        key_clr = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            step();
            check($sformatf("clr_clr[%0d]", n), clr, (n >= 7 && n <= 12));
            check($sformatf("clr_pause[%0d]", n), pause, (n >= 7));
            check($sformatf("clr_ss_press[%0d]", n), ss_press, (n == 8));
            if (n == 2) key_ss = 1'b1;
            if (n == 10) key_clr = 1'b0;
            if (n == 12) key_ss = 1'b0;
        end
        idle(25);

        // Simultaneous press: clear wins, ss press dropped. Second clear press
        // (accepted at cycle 14) reloads the long instance's running hold.
        key_ss  = 1'b1;
        key_clr = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            step();
            check($sformatf("sim_clr[%0d]", n), clr,
                  ((n >= 7 && n <= 12) || (n >= 15 && n <= 20)));
            check($sformatf("sim_pause[%0d]", n), pause, 1'b1);
            check($sformatf("sim_ss_press[%0d]", n), ss_press, (n == 6));
            check($sformatf("sim_long_clr[%0d]", n), clr_l, (n >= 7 && n <= 30));
            check($sformatf("sim_long_pause[%0d]", n), pause_l, 1'b1);
            if (n == 4) begin
                key_ss  = 1'b0;
                key_clr = 1'b0;
            end
            if (n == 8) key_clr = 1'b1;
            if (n == 12) key_clr = 1'b0;
        end
        idle(20);

        // Reset mid-hold: pause to 0, start a clear, reset at cycle 9.
        key_ss = 1'b1;
        idle(8);
        check("rmh_setup_pause", pause, 1'b0);
        key_ss = 1'b0;
        idle(20);
        key_clr = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            step();
            check($sformatf("rmh_clr[%0d]", n), clr, (n >= 7));
        end
        rst = 1'b1;
        step();
        check("rmh_reset_clr", clr, 1'b0);
        check("rmh_reset_pause", pause, 1'b1);
        rst     = 1'b0;
        key_clr = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step();
            check($sformatf("rmh_after_clr[%0d]", n), clr, 1'b0);
            check($sformatf("rmh_after_pause[%0d]", n), pause, 1'b1);
        end

        // Key held through reset: accepted DEBOUNCE_CYCLES+2 = 6 cycles later.
        rst    = 1'b1;
        key_ss = 1'b1;
        idle(2);
        rst = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            step();
            check($sformatf("held_rst_press[%0d]", n), ss_press, (n == 6));
            check($sformatf("held_rst_pause[%0d]", n), pause, (n < 7));
        end
        key_ss = 1'b0;
        idle(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_timer_key_conditioner
